// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter channel: state encoding and bar geometry.
package vu_pkg;

  localparam int unsigned N_SEG   = 15;
  localparam int unsigned LEVEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FALL = 2'd2
  } vu_state_e;

endpackage

// File: rtl/vu_therm.sv
// Combinational thermometer decode of a bar height plus a single peak dot.
module vu_therm
  import vu_pkg::*;
(
  input  logic [LEVEL_W-1:0] bar,
  input  logic [LEVEL_W-1:0] peak,
  output logic [N_SEG-1:0]   leds
);

  always_comb begin
    leds = '0;
    for (int unsigned i = 0; i < N_SEG; i++) begin
      // peak counts segments from 1, so the dot sits at index peak-1
      leds[i] = (i < 32'(bar)) || ((peak != '0) && (i == 32'(peak) - 32'd1));
    end
  end

endmodule

// File: rtl/vu_bar.sv
// VU bar channel: captures a level code as a bar height and runs a peak-hold dot
// that holds for HOLD_TICKS frame ticks and then falls one segment per FALL_TICKS.
module vu_bar
  import vu_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 32,
  parameter int unsigned FALL_TICKS = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               tick,
  input  logic               level_en,
  input  logic [LEVEL_W-1:0] level,
  output logic [N_SEG-1:0]   leds,
  output logic [LEVEL_W-1:0] bar,
  output logic [LEVEL_W-1:0] peak,
  output logic [1:0]         state
);

  localparam logic [CNT_W-1:0]   HOLD_INIT = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0]   FALL_INIT = CNT_W'(FALL_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(N_SEG);
  localparam logic [LEVEL_W-1:0] LVL_ONE   = LEVEL_W'(1);

  logic [LEVEL_W-1:0] bar_q, bar_d;
  logic [LEVEL_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
  vu_state_e          state_q, state_d;

  logic [LEVEL_W-1:0] height;
  logic               reload;

  // level is at most 15, so 15 - level never wraps
  assign height = LVL_MAX - level;
  assign reload = level_en && (height >= peak_q) && (height != '0);

  always_comb begin
    bar_d      = bar_q;
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    fall_cnt_d = fall_cnt_q;
    state_d    = state_q;

    if (level_en) begin
      bar_d = height;
    end

    // A reloading capture swallows a coincident tick; a plain capture does not.
    if (reload) begin
      peak_d = height;
      if (HOLD_TICKS == 0) begin
        state_d    = FALL;
        hold_cnt_d = '0;
        fall_cnt_d = FALL_INIT;
      end else begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_INIT;
        fall_cnt_d = '0;
      end
    end else if (tick) begin
      unique case (state_q)
        HOLD: begin
          if (hold_cnt_q <= CNT_ONE) begin
            hold_cnt_d = '0;
            fall_cnt_d = FALL_INIT;
            state_d    = FALL;
          end else begin
            hold_cnt_d = hold_cnt_q - CNT_ONE;
          end
        end
        FALL: begin
          if (fall_cnt_q <= CNT_ONE) begin
            fall_cnt_d = FALL_INIT;
            if (peak_q <= LVL_ONE) begin
              peak_d  = '0;
              state_d = IDLE;
            end else begin
              peak_d = peak_q - LVL_ONE;
            end
          end else begin
            fall_cnt_d = fall_cnt_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      bar_q      <= '0;
      peak_q     <= '0;
      hold_cnt_q <= '0;
      fall_cnt_q <= '0;
      state_q    <= IDLE;
    end else begin
      bar_q      <= bar_d;
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      state_q    <= state_d;
    end
  end

  vu_therm u_therm (
    .bar  (bar_q),
    .peak (peak_q),
    .leds (leds)
  );

  assign bar   = bar_q;
  assign peak  = peak_q;
  assign state = state_q;

endmodule

// File: tb/tb_vu_bar.sv
// Scoreboard bench for vu_bar with HOLD_TICKS=4, FALL_TICKS=2.
module tb_vu_bar;

  localparam int HOLD = 4;
  localparam int FALLT = 2;

  logic        ck;
  logic        rst;
  logic        tick;
  logic        level_en;
  logic [3:0]  level;
  logic [14:0] leds;
  logic [3:0]  bar;
  logic [3:0]  peak;
  logic [1:0]  state;

  vu_bar #(
    .HOLD_TICKS (HOLD),
    .FALL_TICKS (FALLT),
    .CNT_W      (8)
  ) dut (
    .ck       (ck),
    .rst      (rst),
    .tick     (tick),
    .level_en (level_en),
    .level    (level),
    .leds     (leds),
    .bar      (bar),
    .peak     (peak),
    .state    (state)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [14:0] leds;
    logic [3:0]  bar;
    logic [3:0]  peak;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_bar, m_peak, m_hold, m_fall, m_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bar = 0; m_peak = 0; m_hold = 0; m_fall = 0; m_st = 0;
  endtask

  function automatic logic [14:0] model_leds(input int b, input int p);
    logic [14:0] v;
    v = '0;
    for (int i = 0; i < 15; i++) begin
      if (i < b) v[i] = 1'b1;
    end
    if (p != 0) v[p-1] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input bit t, input bit e, input int lvl);
    int h;
    h = 15 - lvl;
    if (e) m_bar = h;
    if (e && h >= m_peak && h != 0) begin
      m_peak = h;
      m_st   = 1;
      m_hold = HOLD;
    end else if (t) begin
      if (m_st == 1) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) begin
          m_st   = 2;
          m_fall = FALLT;
        end
      end else if (m_st == 2) begin
        m_fall = m_fall - 1;
        if (m_fall == 0) begin
          m_peak = m_peak - 1;
          m_fall = FALLT;
          if (m_peak == 0) m_st = 0;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t x;
    x.leds = model_leds(m_bar, m_peak);
    x.bar  = 4'(m_bar);
    x.peak = 4'(m_peak);
    x.st   = 2'(m_st);
    sb.push_back(x);
  endtask

  task automatic check_outputs();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("sb_leds",  32'(leds),  32'(x.leds));
      chk("sb_bar",   32'(bar),   32'(x.bar));
      chk("sb_peak",  32'(peak),  32'(x.peak));
      chk("sb_state", 32'(state), 32'(x.st));
    end
  endtask

  // drive one cycle of stimulus, predict, then compare after the edge
  task automatic step(input bit t, input bit e, input logic [3:0] lvl);
    @(negedge ck);
    tick     = t;
    level_en = e;
    level    = lvl;
    model_step(t, e, int'(lvl));
    push_expected();
    @(posedge ck);
    #1;
    check_outputs();
    tick     = 1'b0;
    level_en = 1'b0;
  endtask

  int n_ticks;

  initial begin
    rst      = 1'b0;
    tick     = 1'b0;
    level_en = 1'b0;
    level    = 4'd0;
    model_reset();

    // 1. reset
    repeat (3) @(posedge ck);
    @(negedge ck);
    rst = 1'b1;
    #1;
    chk("rst_leds",  32'(leds),  32'd0);
    chk("rst_bar",   32'(bar),   32'd0);
    chk("rst_peak",  32'(peak),  32'd0);
    chk("rst_state", 32'(state), 32'd0);
    repeat (5) step(1'b1, 1'b0, 4'd0);
    chk("idle_ticks_state", 32'(state), 32'd0);

    // 2. first capture
    step(1'b0, 1'b1, 4'd5);
    chk("cap5_leds",  32'(leds),  32'h03FF);
    chk("cap5_bar",   32'(bar),   32'd10);
    chk("cap5_peak",  32'(peak),  32'd10);
    chk("cap5_state", 32'(state), 32'd1);

    // 3. lower capture, hold then fall
    step(1'b0, 1'b1, 4'd12);
    chk("cap12_leds", 32'(leds), 32'h0207);
    chk("cap12_peak", 32'(peak), 32'd10);
    repeat (4) step(1'b1, 1'b0, 4'd0);
    chk("hold_done_state", 32'(state), 32'd2);
    chk("hold_done_peak",  32'(peak),  32'd10);
    repeat (2) step(1'b1, 1'b0, 4'd0);
    chk("fall1_peak", 32'(peak), 32'd9);
    chk("fall1_leds", 32'(leds), 32'h0107);

    // 4. reload with coincident tick
    step(1'b1, 1'b1, 4'd4);
    chk("reload_peak",  32'(peak),  32'd11);
    chk("reload_state", 32'(state), 32'd1);
    chk("reload_leds",  32'(leds),  32'h07FF);
    repeat (3) step(1'b1, 1'b0, 4'd0);
    chk("reload_hold3_state", 32'(state), 32'd1);
    step(1'b1, 1'b0, 4'd0);
    chk("reload_hold4_state", 32'(state), 32'd2);

    // 5. silence, let the dot fall to the floor (bounded)
    step(1'b0, 1'b1, 4'd15);
    chk("silence_bar", 32'(bar), 32'd0);
    n_ticks = 0;
    while (state != 2'd0 && n_ticks < 100) begin
      step(1'b1, 1'b0, 4'd0);
      n_ticks++;
    end
    chk("fall_to_idle_ticks", 32'(n_ticks), 32'd22);
    chk("idle_leds",  32'(leds),  32'd0);
    chk("idle_peak",  32'(peak),  32'd0);

    // 6. async reset mid-FALL with peak=6
    step(1'b0, 1'b1, 4'd9);
    repeat (4) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    chk("prereset_state", 32'(state), 32'd2);
    chk("prereset_peak",  32'(peak),  32'd6);
    @(negedge ck);
    #2;
    rst = 1'b0;
    #1;
    chk("async_leds",  32'(leds),  32'd0);
    chk("async_bar",   32'(bar),   32'd0);
    chk("async_peak",  32'(peak),  32'd0);
    chk("async_state", 32'(state), 32'd0);
    model_reset();
    repeat (2) @(posedge ck);
    @(negedge ck);
    rst = 1'b1;
    step(1'b0, 1'b1, 4'd0);
    chk("full_leds", 32'(leds), 32'h7FFF);
    chk("full_peak", 32'(peak), 32'd15);

    // random traffic against the model, including back-to-back captures
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)));
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vu_bar.md
Name: vu_bar

Overview:
- Downstream consumer of the 4-bit leading-bit level code produced by the level stage.
- Turns each level code into a 15-segment thermometer bar plus a peak-hold dot.
- The dot holds for a programmable number of frame ticks, then falls one segment per programmable tick interval.
- Output drives the front-panel LED bar directly.

Parameters:
- HOLD_TICKS, 32, frame ticks the peak dot holds before falling; 0 means fall immediately.
- FALL_TICKS, 4, frame ticks per one-segment fall of the dot; must be at least 1.
- CNT_W, 8, width of the hold and fall counters; must hold max(HOLD_TICKS, FALL_TICKS).

Ports:
- ck  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- tick  in  1  one-cycle frame strobe that paces hold and fall.
- level_en  in  1  one-cycle pulse; level is valid in the same cycle (driven from the level stage's ready).
- level  in  4  level code; 0 = loudest, 15 = silence.
- leds  out  15  bar plus dot; bit 0 is the bottom segment.
- bar  out  4  current bar height, 0..15.
- peak  out  4  current dot height, 0..15.
- state  out  2  debug: 0 IDLE, 1 HOLD, 2 FALL.

Behaviour:
- Reset (rst low, asynchronous): bar=0, peak=0, hold_cnt=0, fall_cnt=0, state=IDLE, leds=0.
  - Takes effect immediately, including mid-HOLD or mid-FALL.
- Height rule: h = 15 - level, computed in 4-bit unsigned with no wrap (level 0 gives 15, level 15 gives 0).
- Capture: on a ck edge with level_en=1, bar <= h.
  - bar is never decayed; it changes only on capture.
- leds decode, combinational from the registers, so the result is visible the cycle after level_en:
  - leds[i] = (i < bar) OR (peak != 0 AND i == peak-1).
- Peak update on capture:
  - If h >= peak and h != 0: peak <= h, hold_cnt <= HOLD_TICKS, state <= HOLD.
  - If HOLD_TICKS == 0 in that case: state <= FALL and fall_cnt <= FALL_TICKS instead.
  - If h == 0 and peak == 0: stay IDLE.
- IDLE: tick has no effect.
- HOLD: on tick, hold_cnt decrements; when it reaches 0, state <= FALL and fall_cnt <= FALL_TICKS.
- FALL: on tick, fall_cnt decrements. When it reaches 0:
  - peak <= peak-1 and fall_cnt <= FALL_TICKS.
  - If the new peak is 0: state <= IDLE.
- Simultaneous level_en and tick in the same cycle:
  - If the capture reloads the peak (h >= peak, h != 0), the tick is discarded.
  - Otherwise the capture updates bar only and the tick is processed normally.
- Capture during FALL with h >= peak: reload, state back to HOLD, fall progress discarded.
- peak never underflows below 0; counters never underflow.
- No backpressure: level_en is accepted every cycle it is asserted, and back-to-back pulses are legal.

Decomposition:
- Shared package vu_pkg holds:
  - state encoding constants: IDLE=0, HOLD=1, FALL=2.
  - N_SEG=15 and LEVEL_W=4.
- One sub-module, vu_therm: combinational, maps (bar, peak) to leds. It is reused by the other meter channels.

Test Plan (HOLD_TICKS=4, FALL_TICKS=2):
1. Reset: hold rst low 3 cycles, then release → leds=0, bar=0, peak=0, state=IDLE; 5 ticks in IDLE change nothing.
2. level_en with level=5 → next cycle bar=10, peak=10, state=HOLD, leds=15'h03FF.
3. Then level_en with level=12 → bar=3, peak=10, leds=15'h0207. After 4 ticks, state=FALL and peak=10. After 2 more ticks, peak=9 and leds=15'h0107.
4. During FALL with peak=9: tick and level_en with level=4 (h=11) in the same cycle → peak=11, state=HOLD, hold_cnt=4, tick discarded, leds=15'h07FF.
5. level=15 then repeated ticks → bar=0; peak falls by 1 every 2 ticks after the 4-tick hold; reaching peak=0 gives state=IDLE and leds=0.
6. Pull rst low mid-FALL with peak=6 → outputs zero asynchronously, before the next ck edge; after release a level=0 capture gives leds=15'h7FFF and peak=15.
